// File: rtl/bsg_arb_rr_lock.sv
`default_nettype none
// ============================================================================
//  Module   : bsg_arb_rr_lock
//  Purpose  : Fixed-priority / round-robin arbiter with ready gate, yumi
//             handshake and a multi-beat lock on the winning channel.
//  Revision : 1.0  initial release
// ============================================================================
module bsg_arb_rr_lock #(
    parameter int  inputs_p     = 16,
    parameter int  rr_p         = 1,
    parameter int  lo_to_hi_p   = 1,
    localparam int lg_inputs_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [inputs_p-1:0]     reqs_i,
    input  logic                    ready_i,
    input  logic                    yumi_i,
    input  logic                    last_i,
    output logic [inputs_p-1:0]     grants_o,
    output logic [lg_inputs_lp-1:0] grant_id_o,
    output logic                    v_o,
    output logic                    locked_o
);

    localparam logic [lg_inputs_lp-1:0] c_last_idx = lg_inputs_lp'(inputs_p - 1);
    localparam logic [lg_inputs_lp-1:0] c_base     =
        (lo_to_hi_p != 0) ? '0 : lg_inputs_lp'(inputs_p - 1);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [lg_inputs_lp-1:0]   r_ptr;
    logic [lg_inputs_lp-1:0]   w_ptr_nxt;
    logic [lg_inputs_lp-1:0]   r_lock_id;
    logic [lg_inputs_lp-1:0]   w_lock_id_nxt;
    logic [lg_inputs_lp-1:0]   w_start;
    logic [lg_inputs_lp-1:0]   w_shamt;
    logic [lg_inputs_lp-1:0]   w_win_id;
    logic [inputs_p-1:0]       w_src;
    logic [inputs_p-1:0]       w_rot;
    logic [inputs_p-1:0]       w_win_oh;
    logic [inputs_p-1:0]       w_lock_oh;
    logic [2*inputs_p-1:0]     w_dbl;
    logic                      w_found;
    logic                      w_fire;

    // Index reached after moving 'step' places from 'base' in the search
    // direction, wrapping modulo inputs_p.
    function automatic logic [lg_inputs_lp-1:0] f_circ(
        input logic [lg_inputs_lp-1:0] base,
        input int                      step
    );
        int t;
        if (lo_to_hi_p != 0) begin
            t = int'(base) + step;
            if (t >= inputs_p) t = t - inputs_p;
        end else begin
            t = int'(base) - step;
            if (t < 0) t = t + inputs_p;
        end
        return t[lg_inputs_lp-1:0];
    endfunction

    // Descending search is done on the bit-reversed vector so that a single
    // right-rotate brings the start position to bit 0 in both directions.
    generate
        for (genvar i = 0; i < inputs_p; i++) begin : g_src
            assign w_src[i] = (lo_to_hi_p != 0) ? reqs_i[i] : reqs_i[inputs_p-1-i];
        end
    endgenerate

    assign w_start = (rr_p != 0) ? r_ptr : c_base;
    assign w_shamt = (lo_to_hi_p != 0) ? w_start : (c_last_idx - w_start);
    assign w_dbl   = {w_src, w_src} >> w_shamt;
    assign w_rot   = w_dbl[inputs_p-1:0];
    assign w_found = |w_rot;

    always_comb begin
        w_win_id = w_start;
        for (int k = inputs_p - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_win_id = f_circ(w_start, k);
            end
        end
    end

    generate
        for (genvar i = 0; i < inputs_p; i++) begin : g_oh
            localparam logic [lg_inputs_lp-1:0] c_idx = lg_inputs_lp'(i);
            assign w_win_oh[i]  = (w_win_id == c_idx);
            assign w_lock_oh[i] = (r_lock_id == c_idx);
        end
    endgenerate

    always_comb begin
        grants_o   = '0;
        v_o        = 1'b0;
        locked_o   = 1'b0;
        grant_id_o = w_win_id;
        if (!reset_i) begin
            if (r_state == ST_LOCKED) begin
                locked_o   = 1'b1;
                grant_id_o = r_lock_id;
                grants_o   = w_lock_oh & reqs_i & {inputs_p{ready_i}};
                v_o        = (|(w_lock_oh & reqs_i)) & ready_i;
            end else begin
                grants_o   = w_win_oh & {inputs_p{ready_i & w_found}};
                v_o        = w_found & ready_i;
            end
        end
    end

    // v_o already folds in ready_i and reset_i, so an illegal yumi never fires.
    assign w_fire = yumi_i & v_o;

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_lock_id_nxt = r_lock_id;
        if (w_fire) begin
            case (r_state)
                ST_ARB: begin
                    if (!last_i) begin
                        w_state_nxt   = ST_LOCKED;
                        w_lock_id_nxt = grant_id_o;
                    end
                end
                ST_LOCKED: begin
                    if (last_i) begin
                        w_state_nxt = ST_ARB;
                    end
                end
                default: w_state_nxt = ST_ARB;
            endcase
            if ((rr_p != 0) && last_i) begin
                w_ptr_nxt = f_circ(grant_id_o, 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= ST_ARB;
            r_ptr     <= c_base;
            r_lock_id <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_lock_id <= w_lock_id_nxt;
            assert (!(yumi_i && !v_o))
                else $error("bsg_arb_rr_lock: yumi_i asserted without a valid grant");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_arb_rr_lock.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bsg_arb_rr_lock
//  Purpose  : Self-checking bench for three arbiter configurations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bsg_arb_rr_lock;

    logic       clk;
    logic [7:0] reqs;
    logic       ready, last, rst;
    logic [2:0] yumi;

    logic [3:0] ga, gb;
    logic [4:0] gc;
    logic [1:0] ida, idb;
    logic [2:0] idc;
    logic       va, vb, vc, la, lb, lc;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: 4 inputs, round-robin ascending
    bsg_arb_rr_lock #(.inputs_p(4), .rr_p(1), .lo_to_hi_p(1)) u_a (
        .clk_i(clk), .reset_i(rst), .reqs_i(reqs[3:0]), .ready_i(ready),
        .yumi_i(yumi[0]), .last_i(last), .grants_o(ga), .grant_id_o(ida),
        .v_o(va), .locked_o(la));

    // Instance 1: 4 inputs, fixed priority ascending
    bsg_arb_rr_lock #(.inputs_p(4), .rr_p(0), .lo_to_hi_p(1)) u_b (
        .clk_i(clk), .reset_i(rst), .reqs_i(reqs[3:0]), .ready_i(ready),
        .yumi_i(yumi[1]), .last_i(last), .grants_o(gb), .grant_id_o(idb),
        .v_o(vb), .locked_o(lb));

    // Instance 2: 5 inputs, round-robin descending
    bsg_arb_rr_lock #(.inputs_p(5), .rr_p(1), .lo_to_hi_p(0)) u_c (
        .clk_i(clk), .reset_i(rst), .reqs_i(reqs[4:0]), .ready_i(ready),
        .yumi_i(yumi[2]), .last_i(last), .grants_o(gc), .grant_id_o(idc),
        .v_o(vc), .locked_o(lc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit locked;
        int lock_id;
        int ptr;
    } mstate_t;

    mstate_t ms[3];
    int NN[3] = '{4, 4, 5};
    int RR[3] = '{1, 0, 1};
    int LO[3] = '{1, 1, 0};

    function automatic void m_reset(input int k);
        ms[k].locked  = 1'b0;
        ms[k].lock_id = 0;
        ms[k].ptr     = (LO[k] != 0) ? 0 : NN[k] - 1;
    endfunction

    // Priority order: start point, then each next index around the ring.
    function automatic void m_eval(input int k, input logic [7:0] rq, input bit rdy,
                                   output bit v, output int gid);
        int n, start, idx;
        n   = NN[k];
        v   = 1'b0;
        gid = 0;
        if (ms[k].locked) begin
            gid = ms[k].lock_id;
            v   = rq[gid] & rdy;
        end else begin
            start = (RR[k] != 0) ? ms[k].ptr : ((LO[k] != 0) ? 0 : n - 1);
            for (int s = n - 1; s >= 0; s--) begin
                idx = (LO[k] != 0) ? (start + s) % n : (start - s + n) % n;
                if (rq[idx]) begin
                    gid = idx;
                    v   = rdy;
                end
            end
        end
    endfunction

    function automatic void m_step(input int k, input logic [7:0] rq, input bit rdy,
                                   input bit y, input bit lst, input bit rs);
        bit v;
        int gid;
        if (rs) begin
            m_reset(k);
        end else begin
            m_eval(k, rq, rdy, v, gid);
            if (y && v) begin
                if (!ms[k].locked) begin
                    if (!lst) begin
                        ms[k].locked  = 1'b1;
                        ms[k].lock_id = gid;
                    end
                end else if (lst) begin
                    ms[k].locked = 1'b0;
                end
                if (RR[k] != 0 && lst)
                    ms[k].ptr = (LO[k] != 0) ? (gid + 1) % NN[k] : (gid + NN[k] - 1) % NN[k];
            end
        end
    endfunction

    // ---------------- DUT access helpers ----------------
    function automatic logic [7:0] dut_g(input int k);
        case (k)
            0:       return {4'b0, ga};
            1:       return {4'b0, gb};
            default: return {3'b0, gc};
        endcase
    endfunction

    function automatic int dut_id(input int k);
        case (k)
            0:       return int'(ida);
            1:       return int'(idb);
            default: return int'(idc);
        endcase
    endfunction

    function automatic bit dut_v(input int k);
        case (k)
            0:       return va;
            1:       return vb;
            default: return vc;
        endcase
    endfunction

    function automatic bit dut_l(input int k);
        case (k)
            0:       return la;
            1:       return lb;
            default: return lc;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // yumi is only offered to an instance that is presenting a valid grant.
    task automatic drive(input logic [7:0] r, input bit rd, input bit [2:0] want,
                         input bit l, input bit rs);
        @(negedge clk);
        reqs  = r;
        ready = rd;
        last  = l;
        rst   = rs;
        yumi  = 3'b000;
        #1;
        for (int k = 0; k < 3; k++) yumi[k] = want[k] & dut_v(k);
        #1;
    endtask

    task automatic check_all();
        bit v;
        int gid;
        logic [7:0] eg;
        for (int k = 0; k < 3; k++) begin
            m_eval(k, reqs, ready, v, gid);
            if (rst) v = 1'b0;
            eg = v ? (8'd1 << gid) : 8'd0;
            chk($sformatf("dut%0d grants", k), int'(dut_g(k)), int'(eg));
            chk($sformatf("dut%0d v", k), int'(dut_v(k)), int'(v));
            chk($sformatf("dut%0d locked", k), int'(dut_l(k)),
                int'(ms[k].locked & !rst));
            if (v) chk($sformatf("dut%0d grant_id", k), dut_id(k), gid);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) m_step(k, reqs, ready, yumi[k], last, rst);
    endtask

    // ---------------- directed table for instance 0 ----------------
    typedef struct {
        logic [7:0] reqs;
        bit         rdy;
        bit         yumi;
        bit         last;
        bit         rst;
        int         gid;   // -1: don't care
        bit         v;
        bit         lk;
    } vec_t;

    vec_t       tv[18];
    logic [7:0] rr;

    initial begin
        reqs = 8'h00; ready = 1'b0; last = 1'b0; rst = 1'b1; yumi = 3'b000;
        for (int k = 0; k < 3; k++) m_reset(k);

        tv[0]  = '{8'h0F, 1, 0, 1, 1, -1, 0, 0};
        tv[1]  = '{8'h0F, 1, 1, 1, 0,  0, 1, 0};
        tv[2]  = '{8'h0F, 1, 1, 1, 0,  1, 1, 0};
        tv[3]  = '{8'h0F, 1, 1, 1, 0,  2, 1, 0};
        tv[4]  = '{8'h0F, 1, 1, 1, 0,  3, 1, 0};
        tv[5]  = '{8'h0F, 1, 1, 1, 0,  0, 1, 0};
        tv[6]  = '{8'h0F, 0, 0, 1, 0, -1, 0, 0};
        tv[7]  = '{8'h0F, 0, 0, 1, 0, -1, 0, 0};
        tv[8]  = '{8'h0F, 0, 0, 1, 0, -1, 0, 0};
        tv[9]  = '{8'h0F, 1, 1, 1, 0,  1, 1, 0};
        tv[10] = '{8'h0F, 1, 0, 1, 1, -1, 0, 0};
        tv[11] = '{8'h03, 1, 1, 0, 0,  0, 1, 0};
        tv[12] = '{8'h06, 1, 0, 0, 0, -1, 0, 1};
        tv[13] = '{8'h07, 1, 1, 1, 0,  0, 1, 1};
        tv[14] = '{8'h07, 1, 0, 1, 0,  1, 1, 0};
        tv[15] = '{8'h04, 1, 1, 0, 0,  2, 1, 0};
        tv[16] = '{8'h04, 1, 0, 0, 1, -1, 0, 0};
        tv[17] = '{8'h06, 1, 0, 0, 0,  1, 1, 0};

        for (int i = 0; i < 18; i++) begin
            drive(tv[i].reqs, tv[i].rdy, {2'b00, tv[i].yumi}, tv[i].last, tv[i].rst);
            check_all();
            if (tv[i].gid >= 0) chk($sformatf("tv%0d grant_id", i), int'(ida), tv[i].gid);
            chk($sformatf("tv%0d v", i), int'(va), int'(tv[i].v));
            chk($sformatf("tv%0d locked", i), int'(la), int'(tv[i].lk));
            tick();
        end

        // Fixed priority: lowest requesting index always wins.
        drive(8'h0F, 1, 3'b000, 1, 1); check_all(); tick();
        for (int i = 0; i < 3; i++) begin
            drive(8'h0A, 1, 3'b010, 1, 0); check_all();
            chk("fixed 1010 id", int'(idb), 1);
            chk("fixed 1010 grants", int'(gb), 2);
            tick();
        end
        drive(8'h08, 1, 3'b010, 1, 0); check_all();
        chk("fixed 1000 id", int'(idb), 3);
        tick();

        // Five inputs descending: pointer wraps 0 -> 4.
        drive(8'h11, 1, 3'b000, 1, 1); check_all(); tick();
        for (int i = 0; i < 4; i++) begin
            drive(8'h11, 1, 3'b100, 1, 0); check_all();
            chk("desc5 id", int'(idc), (i % 2 == 0) ? 4 : 0);
            chk("desc5 grants", int'(gc), (i % 2 == 0) ? 16 : 1);
            tick();
        end
        // Single request at index 4 after wrap must still be reachable.
        drive(8'h10, 1, 3'b100, 1, 0); check_all();
        chk("desc5 top id", int'(idc), 4);
        tick();

        // Randomised traffic on all three instances against the model.
        drive(8'h00, 1, 3'b000, 1, 1); check_all(); tick();
        for (int c = 0; c < 600; c++) begin
            rr = 8'($urandom);
            if ($urandom_range(3) == 0) rr = rr & 8'($urandom);
            drive(rr, ($urandom_range(9) != 0), 3'($urandom), 1'($urandom_range(1)),
                  ($urandom_range(59) == 0));
            check_all();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
